mmio_fifo_ctrl: RTL

// - Sequences a 64-bit show-ahead sync FIFO from CCI-P MMIO traffic inside the AFU.
// - Host writes to DATA push; host reads of DATA pop. STATUS and CTRL registers provide flush, sticky errors and a one-shot drain.
// - Drain streams FIFO contents to an on-chip consumer over valid/ready.
// - Sits between the AFU MMIO decode (rx.c0 / mmio_hdr) and the FIFO storage. Its read response is muxed onto tx.c2.

---
 rtl/mmio_fifo_pkg.sv | 22 ++
 rtl/mmio_fifo_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_pkg.sv
// Register map, bit positions and controller state type shared by the MMIO FIFO controller.
package mmio_fifo_pkg;

    localparam logic [15:0] OFF_DATA   = 16'd0;
    localparam logic [15:0] OFF_STATUS = 16'd2;
    localparam logic [15:0] OFF_CTRL   = 16'd4;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_UDF       = 3;
    localparam int unsigned ST_PERR      = 4;
    localparam int unsigned ST_DRAIN     = 5;
    localparam int unsigned ST_COUNT_LSB = 16;

    localparam int unsigned CTRL_FLUSH = 0;
    localparam int unsigned CTRL_CLEAR = 1;
    localparam int unsigned CTRL_DRAIN = 2;

    typedef enum logic {IDLE, DRAIN} ctrl_state_t;

endpackage

// File: rtl/mmio_fifo_ctrl.sv
// MMIO front end for a show-ahead FIFO: DATA push/pop, STATUS/CTRL registers and a
// one-shot drain onto a valid/ready stream.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0020,
    parameter int unsigned TIDW      = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mmio_wr_valid_i,
    input  logic            mmio_rd_valid_i,
    input  logic [15:0]     mmio_addr_i,
    input  logic [TIDW-1:0] mmio_tid_i,
    input  logic [63:0]     mmio_wdata_i,
    output logic            rsp_valid_o,
    output logic [TIDW-1:0] rsp_tid_o,
    output logic [63:0]     rsp_data_o,
    output logic            fifo_push_o,
    output logic            fifo_pop_o,
    output logic            fifo_flush_o,
    output logic [63:0]     fifo_wdata_o,
    input  logic [63:0]     fifo_rdata_i,
    input  logic            fifo_full_i,
    input  logic            fifo_empty_i,
    output logic            strm_valid_o,
    output logic [63:0]     strm_data_o,
    input  logic            strm_ready_i
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [15:0] ADDR_DATA   = BASE_ADDR + OFF_DATA;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + OFF_STATUS;
    localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + OFF_CTRL;

    ctrl_state_t     state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d, udf_q, udf_d, perr_q, perr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [TIDW-1:0] rsp_tid_q, rsp_tid_d;
    logic [63:0]     rsp_data_q, rsp_data_d;

    logic        hit_data, hit_status, hit_ctrl, owned, rd_ok, ctrl_wr;
    logic        flush, clear, start, push, pop, host_pop, drain_pop, strm_valid;
    logic        ovf_set, udf_set, perr_set;
    logic [63:0] status;

    always_comb begin
        hit_data   = mmio_addr_i == ADDR_DATA;
        hit_status = mmio_addr_i == ADDR_STATUS;
        hit_ctrl   = mmio_addr_i == ADDR_CTRL;
        owned      = hit_data | hit_status | hit_ctrl;
        // A read colliding with a write is dropped; the write still goes through.
        rd_ok      = mmio_rd_valid_i & ~mmio_wr_valid_i & owned;
        ctrl_wr    = mmio_wr_valid_i & hit_ctrl;
        flush      = ctrl_wr & mmio_wdata_i[CTRL_FLUSH];
        clear      = ctrl_wr & mmio_wdata_i[CTRL_CLEAR];
        start      = ctrl_wr & mmio_wdata_i[CTRL_DRAIN] & ~mmio_wdata_i[CTRL_FLUSH]
                     & (state_q == IDLE);
        push       = mmio_wr_valid_i & hit_data & ~fifo_full_i;
        strm_valid = (state_q == DRAIN) & ~fifo_empty_i;
        drain_pop  = strm_valid & strm_ready_i;
        host_pop   = rd_ok & hit_data & (state_q == IDLE) & ~fifo_empty_i;
        pop        = (drain_pop | host_pop) & ~flush;

        ovf_set  = mmio_wr_valid_i & hit_data & fifo_full_i;
        udf_set  = rd_ok & hit_data & (state_q == IDLE) & fifo_empty_i;
        perr_set = (rd_ok & hit_data & (state_q == DRAIN))
                   | (mmio_wr_valid_i & mmio_rd_valid_i & owned);

        // Sticky set wins over a clear arriving in the same cycle.
        ovf_d  = (ovf_q & ~clear) | ovf_set;
        udf_d  = (udf_q & ~clear) | udf_set;
        perr_d = (perr_q & ~clear) | perr_set;

        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (flush) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = DRAIN;
        end else if ((state_q == DRAIN) && (count_d == '0)) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        status                        = '0;
        status[ST_EMPTY]              = count_q == '0;
        status[ST_FULL]               = count_q == CW'(DEPTH);
        status[ST_OVF]                = ovf_q;
        status[ST_UDF]                = udf_q;
        status[ST_PERR]               = perr_q;
        status[ST_DRAIN]              = state_q == DRAIN;
        status[ST_COUNT_LSB +: 16]    = 16'(count_q);

        rsp_valid_d = rd_ok;
        rsp_tid_d   = rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_ok) begin
            rsp_tid_d  = mmio_tid_i;
            rsp_data_d = hit_status ? status : (host_pop ? fifo_rdata_i : 64'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            perr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            perr_q      <= perr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Strobes are held low for the whole reset window, not just after it.
    assign fifo_push_o  = push & ~rst;
    assign fifo_pop_o   = pop & ~rst;
    assign fifo_flush_o = flush & ~rst;
    assign strm_valid_o = strm_valid & ~rst;
    assign fifo_wdata_o = mmio_wdata_i;
    assign strm_data_o  = fifo_rdata_i;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_tid_o    = rsp_tid_q;
    assign rsp_data_o   = rsp_data_q;

endmodule
